// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller:
// operation codes, HI/LO direct-write codes, latencies and FSM encoding.
package mdu_ctrl_pkg;

    localparam logic [1:0] MDOP_MULT  = 2'b00;
    localparam logic [1:0] MDOP_MULTU = 2'b01;
    localparam logic [1:0] MDOP_DIV   = 2'b10;
    localparam logic [1:0] MDOP_DIVU  = 2'b11;

    localparam logic [1:0] HILO_NONE  = 2'b00;
    localparam logic [1:0] HILO_HI    = 2'b01;
    localparam logic [1:0] HILO_LO    = 2'b10;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_ctrl.sv
// Multiply/divide unit controller: fixed-latency mult/multu/div/divu with
// architectural HI/LO registers and mthi/mtlo direct writes.
// Configuration macro: MDU_DIV_EN -- when defined, div/divu are supported;
// otherwise a divide Start is ignored and no divider is built.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [1:0]  HiLoWr,
    input  logic [31:0] WD,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic        busy_q;
    logic [31:0] hi_q, lo_q;
    logic        op_ok, take, done;
    logic [63:0] ext_a, ext_b, prod;
    logic [31:0] res_hi, res_lo;
    logic        res_ok;

`ifdef MDU_DIV_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~MDOp[1];
`endif

    // Next-state logic: accept a supported Start in IDLE, finish when the counter hits 0.
    always_comb begin
        state_n = state;
        take    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (Start && op_ok) begin
                take    = 1'b1;
                state_n = BUSY;
            end
            BUSY: if (cnt == 4'd0) begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Result datapath from the captured operands; one multiplier serves both signednesses.
    always_comb begin
        ext_a  = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
        ext_b  = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
        prod   = ext_a * ext_b;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MDU_DIV_EN
        // Divide by zero still runs the full latency but never commits.
        res_ok = ~op_q[1] | (b_q != 32'd0);
        if (op_q[1] && b_q != 32'd0) begin
            if (op_q[0]) begin
                res_lo = a_q / b_q;
                res_hi = a_q % b_q;
            end else begin
                res_lo = $unsigned($signed(a_q) / $signed(b_q));
                res_hi = $unsigned($signed(a_q) % $signed(b_q));
            end
        end
`else
        // Divides are never accepted here; this only keeps op_q fully used.
        res_ok = ~op_q[1];
`endif
    end

    // State register plus registered Busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            busy_q <= (state_n == BUSY);
        end
    end

    // Operand capture, latency counter and HI/LO update (commit beats direct write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 4'd0;
            op_q <= 2'b00;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (take) begin
                op_q <= MDOp;
                a_q  <= A;
                b_q  <= B;
                cnt  <= MDOp[1] ? 4'(DIV_CYC - 1) : 4'(MULT_CYC - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (done && res_ok) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state == IDLE && !take) begin
                case (HiLoWr)
                    HILO_HI: hi_q <= WD;
                    HILO_LO: lo_q <= WD;
                    default: ;
                endcase
            end
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: cycle-level reference model compared every
// cycle, plus hand-computed literal expectations for the directed vectors.
module tb_mdu_ctrl;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  MDOp = 2'b00;
    logic [31:0] A = '0, B = '0;
    logic [1:0]  HiLoWr = 2'b00;
    logic [31:0] WD = '0;
    logic        Busy;
    logic [31:0] HI, LO;

    int errors = 0;
    int checks = 0;

    mdu_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoWr(HiLoWr), .WD(WD), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: remaining busy cycles and the result owed at the end.
    int          m_left = 0;
    logic        m_has = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0; m_has = 1'b0; m_hi = '0; m_lo = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_has) begin
                m_hi = m_rhi; m_lo = m_rlo;
            end
        end else if (Start && (!MDOp[1] || DIV_EN)) begin
            if (!MDOp[1]) begin
                longint sa, sb, p;
                if (MDOp[0]) begin sa = longint'({32'b0, A}); sb = longint'({32'b0, B}); end
                else begin sa = longint'($signed(A)); sb = longint'($signed(B)); end
                p = sa * sb;
                m_rhi = p[63:32]; m_rlo = p[31:0];
                m_has = 1'b1; m_left = 5;
            end else begin
                m_has = (B != 0); m_left = 10;
                if (B != 0) begin
                    if (MDOp[0]) begin m_rlo = A / B; m_rhi = A % B; end
                    else begin
                        int sa, sb;
                        sa = $signed(A); sb = $signed(B);
                        m_rlo = sa / sb; m_rhi = sa % sb;
                    end
                end
            end
        end else if (HiLoWr == 2'b01) m_hi = WD;
        else if (HiLoWr == 2'b10) m_lo = WD;
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_busy", {31'b0, Busy}, {31'b0, m_left > 0});
            chk("model_hi", HI, m_hi);
            chk("model_lo", LO, m_lo);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge clk);
        Start = 1'b0;
    endtask

    // Issue an operation and count Busy cycles (bounded), then check HI/LO literals.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] ehi,
                          input logic [31:0] elo);
        int n;
        issue(op, a, b);
        n = 0;
        while (Busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk({nm, "_cycles"}, 32'(n), 32'(cyc));
        chk({nm, "_hi"}, HI, ehi);
        chk({nm, "_lo"}, LO, elo);
    endtask

    task automatic hilo_wr(input logic [1:0] w, input logic [31:0] d);
        @(negedge clk);
        HiLoWr = w; WD = d;
        @(negedge clk);
        HiLoWr = 2'b00;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        rst_n = 1'b1;

        hilo_wr(2'b01, 32'hAAAA5555);
        chk("mthi", HI, 32'hAAAA5555);
        hilo_wr(2'b10, 32'h5555AAAA);
        chk("mtlo", LO, 32'h5555AAAA);
        hilo_wr(2'b11, 32'h0BAD0BAD);
        chk("nowr_hi", HI, 32'hAAAA5555);
        chk("nowr_lo", LO, 32'h5555AAAA);

        run_op("mult", 2'b00, 32'hFFFFFFFF, 32'd2, 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_op("multu", 2'b01, 32'hFFFFFFFF, 32'd2, 5, 32'h00000001, 32'hFFFFFFFE);
        run_op("mult_min", 2'b00, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0);
        run_op("multu_big", 2'b01, 32'h80000000, 32'h80000000, 5, 32'h40000000, 32'h0);
        run_op("div", 2'b10, 32'hFFFFFFF9, 32'd2, DIV_EN ? 10 : 0,
               DIV_EN ? 32'hFFFFFFFF : 32'h40000000, DIV_EN ? 32'hFFFFFFFD : 32'h0);
        run_op("divu", 2'b11, 32'd7, 32'd2, DIV_EN ? 10 : 0,
               DIV_EN ? 32'd1 : 32'h40000000, DIV_EN ? 32'd3 : 32'h0);

        hilo_wr(2'b01, 32'h1234);
        run_op("div0", 2'b10, 32'd99, 32'd0, DIV_EN ? 10 : 0,
               32'h1234, DIV_EN ? 32'd3 : 32'h0);

        // Second Start and a mtlo during BUSY are both ignored.
        issue(2'b00, 32'd3, 32'd5);
        Start = 1'b1; MDOp = 2'b01; A = 32'd100; B = 32'd100;
        HiLoWr = 2'b10; WD = 32'hDEADDEAD;
        @(negedge clk);
        Start = 1'b0; HiLoWr = 2'b00;
        n = 0;
        while (Busy && n < 20) begin n++; @(negedge clk); end
        chk("overlap_cycles", 32'(n), 32'd4);
        chk("overlap_hi", HI, 32'd0);
        chk("overlap_lo", LO, 32'd15);
        repeat (3) @(negedge clk);
        chk("overlap_idle", {31'b0, Busy}, 32'd0);

        // Start and mtlo together in IDLE: Start wins.
        @(negedge clk);
        Start = 1'b1; MDOp = 2'b00; A = 32'd2; B = 32'd3;
        HiLoWr = 2'b10; WD = 32'hBEEF;
        @(negedge clk);
        Start = 1'b0; HiLoWr = 2'b00;
        chk("startwin_busy", {31'b0, Busy}, 32'd1);
        chk("startwin_lo_hold", LO, 32'd15);
        n = 0;
        while (Busy && n < 20) begin n++; @(negedge clk); end
        chk("startwin_lo", LO, 32'd6);

        // Reset in the third BUSY cycle aborts with no commit.
        issue(2'b00, 32'd6, 32'd7);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_nocommit_lo", LO, 32'd0);
        chk("abort_nocommit_busy", {31'b0, Busy}, 32'd0);

        run_op("resume", 2'b01, 32'd10, 32'd11, 5, 32'd0, 32'd110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-003 Start  input  1  one-cycle pulse from the decoder: multiply/divide issue (mult/multu/div/divu).
REQ-004 MDOp  input  2  operation select, sampled with Start: 00 mult, 01 multu, 10 div, 11 divu.
REQ-005 A  input  32  rs operand, sampled with Start.
REQ-006 B  input  32  rt operand, sampled with Start.
REQ-007 HiLoWr  input  2  direct write: 01 mthi, 10 mtlo, 00/11 no write.
REQ-008 WD  input  32  data for the HiLoWr write.
REQ-009 Busy  output  1  registered; high while an operation is in flight.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 The block SHALL be a two-state FSM: IDLE and BUSY.
REQ-013 In IDLE with Start=1 at an edge, the block SHALL capture MDOp/A/B, load the counter with latency-1 and enter BUSY.
REQ-014 Latency SHALL be 5 cycles for mult/multu and 10 cycles for div/divu.
REQ-015 Busy SHALL be high exactly N cycles, starting the cycle after the Start edge.
REQ-016 HI/LO SHALL update at the edge ending the last Busy cycle; that same edge SHALL return the FSM to IDLE with Busy=0.
REQ-017 The counter SHALL decrement once per BUSY cycle; the FSM SHALL leave BUSY when the counter reads 0.
REQ-018 mult SHALL compute the signed 64-bit product; multu the unsigned product. HI = bits 63:32, LO = bits 31:0.
REQ-019 div SHALL produce signed results: LO = quotient truncated toward zero, HI = remainder with the dividend's sign. divu SHALL produce unsigned results.
REQ-020 Division with B=0 SHALL run the full 10 cycles and leave HI/LO unchanged.
REQ-021 A Start received while Busy=1 SHALL be ignored; the upstream pipeline stalls on Busy.
REQ-022 In IDLE, HiLoWr=01 SHALL write WD to HI and HiLoWr=10 SHALL write WD to LO at the next edge.
REQ-023 HiLoWr received while Busy=1 SHALL be ignored.
REQ-024 When Start and HiLoWr are high in the same IDLE cycle, Start SHALL win and the write SHALL be dropped.
REQ-025 HI/LO SHALL hold their value in every cycle with no commit and no write.

Reset
REQ-026 When rst_n=0, the block SHALL asynchronously force: FSM to IDLE, counter=0, Busy=0, HI=0, LO=0, captured operands=0.
REQ-027 A reset during BUSY SHALL abort the operation with no commit.
REQ-028 Operation SHALL resume on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro MDU_DIV_EN: when defined, div/divu SHALL be supported as specified above.
REQ-030 When MDU_DIV_EN is undefined:
- Start with MDOp=1x SHALL be ignored (FSM stays IDLE, Busy stays 0, HI/LO unchanged).
- No divider logic SHALL be synthesized.

Structure
REQ-031 A shared package SHALL hold:
- MDOp codes;
- HiLoWr codes;
- MULT_CYC=5 and DIV_CYC=10;
- the FSM state encoding.
REQ-032 The block SHALL be a single module with no sub-module; all arithmetic is inline.

Verification
REQ-033 mult, A=0xFFFFFFFF, B=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-034 multu, A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
REQ-035 div, A=0xFFFFFFF9, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 cycles; divu, A=7, B=2 -> LO=3, HI=1.
REQ-036 Start div with B=0 after mthi 0x1234 -> Busy high 10 cycles, then HI=0x1234 unchanged.
REQ-037 Start mult, drop rst_n in cycle 3 of BUSY -> immediately Busy=0, HI=LO=0, and no later commit.
REQ-038 Second Start plus HiLoWr=10 during BUSY -> both ignored; only the first result commits.
